// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - load/store funct3 codes and responder state type
package datamem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dm_state_t;

endpackage

// File: rtl/datamem_responder_if.sv
// rtl/datamem_responder_if.sv - core load/store port bundle
interface datamem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ready;
  logic              misalign_err;

  modport master (output rd, wr, addr, funct3, wr_data,
                  input  rd_data, ready, misalign_err);
  modport slave  (input  rd, wr, addr, funct3, wr_data,
                  output rd_data, ready, misalign_err);
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, load extension and alignment check
module lsu_lane_align
  import datamem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic       is_b;
  logic       is_h;
  logic       sext;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    is_b       = (funct3 == F3_B) || (funct3 == F3_BU);
    is_h       = (funct3 == F3_H) || (funct3 == F3_HU);
    sext       = ~funct3[2];
    misaligned = (is_h && addr_lo[0]) || (!is_b && !is_h && (addr_lo != 2'b00));
    b_sel      = rd_word[{addr_lo, 3'b000} +: 8];
    h_sel      = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    byte_en    = 4'b1111;
    st_data    = wr_data;
    ld_data    = rd_word;
    // Narrow stores replicate the source so any enabled lane sees the right byte.
    if (is_b) begin
      byte_en = 4'b0001 << addr_lo;
      st_data = {4{wr_data[7:0]}};
      ld_data = {{24{sext & b_sel[7]}}, b_sel};
    end else if (is_h) begin
      byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      st_data = {2{wr_data[15:0]}};
      ld_data = {{16{sext & h_sel[15]}}, h_sel};
    end
    if (misaligned) begin
      byte_en = 4'b0000;
    end
  end

endmodule

// File: rtl/datamem_responder.sv
// rtl/datamem_responder.sv - wait-stated data-memory responder for the core load/store port
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  datamem_responder_if.slave bus
);

  localparam int         DEPTH     = (2 ** ADDR_W) / 4;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [3:0][7:0] mem [DEPTH];

  dm_state_t         state;
  logic [3:0]        cnt;
  logic              l_rd;
  logic              l_wr;
  logic [ADDR_W-1:0] l_addr;
  logic [2:0]        l_f3;
  logic [DATA_W-1:0] l_wdata;

  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        cur_f3;
  logic [DATA_W-1:0] cur_wdata;
  logic              idle_go;
  logic              enter_resp;
  logic [3:0]        byte_en;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic [31:0]       rd_word;
  logic              mis;

  // With zero wait states the access happens in the accept cycle, before the latches fill.
  always_comb begin
    cur_wr     = (state == IDLE) ? bus.wr      : l_wr;
    cur_addr   = (state == IDLE) ? bus.addr    : l_addr;
    cur_f3     = (state == IDLE) ? bus.funct3  : l_f3;
    cur_wdata  = (state == IDLE) ? bus.wr_data : l_wdata;
    idle_go    = (state == IDLE) && (bus.rd || bus.wr);
    enter_resp = (idle_go && (WAIT_CYCLES == 0)) || ((state == BUSY) && (cnt == 4'd0));
    rd_word    = mem[cur_addr[ADDR_W-1:2]];
  end

  lsu_lane_align u_align (
    .funct3     (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .wr_data    (cur_wdata),
    .rd_word    (rd_word),
    .byte_en    (byte_en),
    .st_data    (st_data),
    .ld_data    (ld_data),
    .misaligned (mis)
  );

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_addr[ADDR_W-1:2]][b] <= st_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      bus.ready        <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.rd_data      <= '0;
    end else begin
      bus.ready <= enter_resp;
      if (enter_resp) begin
        bus.rd_data      <= (mis || cur_wr) ? '0 : ld_data;
        bus.misalign_err <= mis;
      end
      case (state)
        IDLE: begin
          if (idle_go) begin
            l_rd    <= bus.rd;
            l_wr    <= bus.wr;
            l_addr  <= bus.addr;
            l_f3    <= bus.funct3;
            l_wdata <= bus.wr_data;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= WAIT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_rd;
  assign unused_rd = l_rd;

endmodule

// File: tb/tb_datamem_responder.sv
// tb/tb_datamem_responder.sv - randomized and directed bench for datamem_responder
module tb_datamem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_v   [3];
  logic        wr_v   [3];
  logic [8:0]  addr_v [3];
  logic [2:0]  f3_v   [3];
  logic [31:0] wd_v   [3];
  logic [31:0] rdd_v  [3];
  logic [2:0]  ready_v;
  logic [2:0]  err_v;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [3][512];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    datamem_responder_if #(.DATA_W(32), .ADDR_W(9)) dmi ();
    datamem_responder #(
      .DATA_W(32), .ADDR_W(9), .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dmi.slave)
    );
    assign dmi.rd      = rd_v[g];
    assign dmi.wr      = wr_v[g];
    assign dmi.addr    = addr_v[g];
    assign dmi.funct3  = f3_v[g];
    assign dmi.wr_data = wd_v[g];
    assign rdd_v[g]    = dmi.rd_data;
    assign ready_v[g]  = dmi.ready;
    assign err_v[g]    = dmi.misalign_err;
  end

  function automatic int lat_of(input int which);
    return (which == 0) ? 1 : (which == 1) ? 2 : 4;
  endfunction

  // Little-endian byte-array model of one responder's memory.
  function automatic void model(input int which, input bit r, input bit w,
                                input logic [8:0] a, input logic [2:0] f3,
                                input logic [31:0] wd,
                                output logic [31:0] d, output bit e);
    int unsigned size;
    int unsigned val;
    bit          signd;
    size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    signd = (f3 == 3'd0 || f3 == 3'd1);
    d = 32'd0;
    e = (int'(a) % size) != 0;
    if (e) return;
    if (w) begin
      for (int i = 0; i < int'(size); i++) ref_mem[which][int'(a) + i] = wd[8*i +: 8];
    end else if (r) begin
      val = 0;
      for (int i = 0; i < int'(size); i++) val = val + (int'(ref_mem[which][int'(a) + i]) << (8*i));
      if (signd && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
      d = val;
    end
  endfunction

  task automatic access(input int which, input bit r, input bit w, input logic [8:0] a,
                        input logic [2:0] f3, input logic [31:0] wd, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    int          cyc;
    bit          got;
    model(which, r, w, a, f3, wd, exp_d, exp_e);
    rd_v[which] = r; wr_v[which] = w; addr_v[which] = a; f3_v[which] = f3; wd_v[which] = wd;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_v[which]) got = 1;
    end
    rd_v[which] = 1'b0; wr_v[which] = 1'b0;
    checks++;
    assert (got === 1'b1 && cyc === lat_of(which)) else begin
      errors++; $error("FAIL %s latency got=%0d exp=%0d", tag, cyc, lat_of(which));
    end
    checks++;
    assert (rdd_v[which] === exp_d) else begin
      errors++; $error("FAIL %s rd_data got=%h exp=%h", tag, rdd_v[which], exp_d);
    end
    checks++;
    assert (err_v[which] === exp_e) else begin
      errors++; $error("FAIL %s misalign_err got=%b exp=%b", tag, err_v[which], exp_e);
    end
    @(posedge clk); #1;
    checks++;
    assert (ready_v[which] === 1'b0 && rdd_v[which] === exp_d) else begin
      errors++; $error("FAIL %s after ready got ready=%b data=%h exp ready=0 data=%h",
                       tag, ready_v[which], rdd_v[which], exp_d);
    end
  endtask

  initial begin
    logic [31:0] exp_d;
    bit          exp_e;
    int          cyc;
    int          seen;
    logic [2:0]  f3_tbl [8];
    f3_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int k = 0; k < 3; k++) begin
      rd_v[k] = 0; wr_v[k] = 0; addr_v[k] = 0; f3_v[k] = 0; wd_v[k] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (ready_v === 3'b000 && err_v === 3'b000 && rdd_v[1] === 32'd0) else begin
      errors++; $error("FAIL reset got ready=%b err=%b data=%h exp 0/0/0", ready_v, err_v, rdd_v[1]);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 1, 9'h010, 3'd2, 32'hDEADBEEF, "sw_word");
    access(1, 1, 0, 9'h010, 3'd2, 32'h0, "lw_word");
    access(1, 1, 0, 9'h013, 3'd0, 32'h0, "lb_13");
    access(1, 1, 0, 9'h013, 3'd4, 32'h0, "lbu_13");
    access(1, 1, 0, 9'h012, 3'd1, 32'h0, "lh_12");
    access(1, 1, 0, 9'h010, 3'd5, 32'h0, "lhu_10");
    access(1, 0, 1, 9'h011, 3'd0, 32'h00000055, "sb_11");
    access(1, 1, 0, 9'h010, 3'd2, 32'h0, "lw_after_sb");
    access(1, 0, 1, 9'h012, 3'd1, 32'h00001234, "sh_12");
    access(1, 1, 0, 9'h010, 3'd2, 32'h0, "lw_after_sh");
    access(1, 1, 0, 9'h011, 3'd2, 32'h0, "lw_misaligned");
    access(1, 0, 1, 9'h013, 3'd1, 32'hFFFFFFFF, "sh_misaligned");
    access(1, 1, 0, 9'h010, 3'd2, 32'h0, "lw_after_bad_sh");

    access(1, 0, 1, 9'h020, 3'd2, 32'h11223344, "sw_prior_20");
    rd_v[1] = 0; wr_v[1] = 1; addr_v[1] = 9'h020; f3_v[1] = 3'd2; wd_v[1] = 32'hAAAAAAAA;
    @(posedge clk); #1;
    wr_v[1] = 0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready_v[1]) seen++;
    end
    checks++;
    assert (seen === 0) else begin
      errors++; $error("FAIL reset_busy ready pulses got=%0d exp=0", seen);
    end
    access(1, 1, 0, 9'h020, 3'd2, 32'h0, "lw_after_reset_busy");

    access(1, 1, 1, 9'h024, 3'd2, 32'hCAFEF00D, "rd_wr_both");
    access(1, 1, 0, 9'h024, 3'd2, 32'h0, "lw_after_both");

    model(1, 1, 0, 9'h010, 3'd2, 32'h0, exp_d, exp_e);
    rd_v[1] = 1; addr_v[1] = 9'h010; f3_v[1] = 3'd2;
    for (int p = 0; p < 2; p++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!ready_v[1] && cyc < 20);
      if (p == 1) rd_v[1] = 0;
      checks++;
      assert (ready_v[1] === 1'b1 && cyc === ((p == 0) ? 2 : 3) && rdd_v[1] === exp_d) else begin
        errors++; $error("FAIL hold_rd pass%0d got cyc=%0d data=%h exp cyc=%0d data=%h",
                         p, cyc, rdd_v[1], (p == 0) ? 2 : 3, exp_d);
      end
    end
    @(posedge clk); #1;

    access(0, 0, 1, 9'h030, 3'd2, 32'h0BADF00D, "w0_sw");
    access(0, 1, 0, 9'h032, 3'd1, 32'h0, "w0_lh");
    access(2, 0, 1, 9'h030, 3'd2, 32'h87654321, "w3_sw");
    access(2, 1, 0, 9'h031, 3'd0, 32'h0, "w3_lb");

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) access(k, 0, 1, 9'(9'h040 + 4*j), 3'd2, $urandom, "rand_init");
    end
    for (int i = 0; i < 60; i++) begin
      int          which;
      int          kind;
      which = $urandom_range(0, 2);
      kind  = $urandom_range(0, 3);
      access(which, kind != 1, kind == 1 || kind == 3,
             9'(9'h040 + $urandom_range(0, 31)), f3_tbl[$urandom_range(0, 7)], $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
